// File: rtl/la32r_pkg.sv
// LA32R shared definitions: load-op encodings and MEM-stage FSM states.
`default_nettype none

package la32r_pkg;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_HOLD = 2'b10
    } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// EX->MEM payload, data-SRAM response, MEM->WB payload and ID forwarding info.
`default_nettype none

interface mem_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          ex_to_mem_valid;
    logic          mem_allow_in;
    logic [31:0]   ex_pc;
    logic [DW-1:0] ex_result;
    logic          ex_is_load;
    logic [2:0]    ex_ld_op;
    logic [3:0]    ex_rf_we;
    logic [AW-1:0] ex_rf_waddr;
    logic          data_sram_data_ok;
    logic [DW-1:0] data_sram_rdata;
    logic          wb_allow_in;
    logic          to_wb_valid;
    logic [31:0]   pc_out;
    logic [3:0]    rf_we_out;
    logic [AW-1:0] rf_waddr_out;
    logic [DW-1:0] rf_wdata_out;
    logic          fwd_we;
    logic          fwd_block;

    modport master (
        output ex_to_mem_valid, ex_pc, ex_result, ex_is_load, ex_ld_op,
               ex_rf_we, ex_rf_waddr, data_sram_data_ok, data_sram_rdata, wb_allow_in,
        input  mem_allow_in, to_wb_valid, pc_out, rf_we_out, rf_waddr_out,
               rf_wdata_out, fwd_we, fwd_block
    );

    modport slave (
        input  ex_to_mem_valid, ex_pc, ex_result, ex_is_load, ex_ld_op,
               ex_rf_we, ex_rf_waddr, data_sram_data_ok, data_sram_rdata, wb_allow_in,
        output mem_allow_in, to_wb_valid, pc_out, rf_we_out, rf_waddr_out,
               rf_wdata_out, fwd_we, fwd_block
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half of a load response and sign/zero extends it.
`default_nettype none

module load_align
    import la32r_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    ld_op_i,
    input  logic [1:0]    addr_i,
    input  logic [DW-1:0] rdata_i,
    output logic [DW-1:0] wdata_o
);
    logic [7:0]  byte_d;
    logic [15:0] half_d;

    always_comb begin
        byte_d  = rdata_i[8*addr_i +: 8];
        // addr_i[0] is ignored for halves; misaligned halves never reach here
        half_d  = rdata_i[16*addr_i[1] +: 16];
        wdata_o = rdata_i;
        case (ld_op_i)
            LD_B:    wdata_o = {{(DW-8){byte_d[7]}}, byte_d};
            LD_BU:   wdata_o = {{(DW-8){1'b0}}, byte_d};
            LD_H:    wdata_o = {{(DW-16){half_d[15]}}, half_d};
            LD_HU:   wdata_o = {{(DW-16){1'b0}}, half_d};
            default: wdata_o = rdata_i;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// LA32R MEM stage: latches EX results, waits for load data, hands results to WB.
`default_nettype none

module mem_stage
    import la32r_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    mem_stage_if.slave    bus
);
    logic          mem_valid_q;
    logic [31:0]   pc_q;
    logic [DW-1:0] result_q;
    logic          is_load_q;
    logic [2:0]    ld_op_q;
    logic [3:0]    rf_we_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] buf_q, buf_d;
    mem_state_e    state_q, state_d;

    logic          ready_go;
    logic          allow_in;
    logic          transfer;
    logic          load_in;
    logic [DW-1:0] rdata_sel;
    logic [DW-1:0] ld_wdata;

    always_comb begin
        ready_go = 1'b1;
        if (state_q == MEM_WAIT) ready_go = bus.data_sram_data_ok;
    end

    assign allow_in = !mem_valid_q || (ready_go && bus.wb_allow_in);
    assign transfer = mem_valid_q && ready_go && bus.wb_allow_in;
    assign load_in  = allow_in && bus.ex_to_mem_valid && bus.ex_is_load;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        case (state_q)
            MEM_IDLE: if (load_in) state_d = MEM_WAIT;
            MEM_WAIT: begin
                if (bus.data_sram_data_ok) begin
                    if (bus.wb_allow_in) begin
                        state_d = load_in ? MEM_WAIT : MEM_IDLE;
                    end else begin
                        state_d = MEM_HOLD;
                        buf_d   = bus.data_sram_rdata;
                    end
                end
            end
            MEM_HOLD: if (transfer) state_d = load_in ? MEM_WAIT : MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= MEM_IDLE;
            buf_q       <= '0;
            mem_valid_q <= 1'b0;
            pc_q        <= '0;
            result_q    <= '0;
            is_load_q   <= 1'b0;
            ld_op_q     <= '0;
            rf_we_q     <= '0;
            waddr_q     <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            if (allow_in) begin
                mem_valid_q <= bus.ex_to_mem_valid;
                if (bus.ex_to_mem_valid) begin
                    pc_q      <= bus.ex_pc;
                    result_q  <= bus.ex_result;
                    is_load_q <= bus.ex_is_load;
                    ld_op_q   <= bus.ex_ld_op;
                    rf_we_q   <= bus.ex_rf_we;
                    waddr_q   <= bus.ex_rf_waddr;
                end
            end
        end
    end

    // WAIT bypasses the live response; HOLD replays the captured word
    assign rdata_sel = (state_q == MEM_HOLD) ? buf_q : bus.data_sram_rdata;

    load_align #(.DW(DW)) u_load_align (
        .ld_op_i (ld_op_q),
        .addr_i  (result_q[1:0]),
        .rdata_i (rdata_sel),
        .wdata_o (ld_wdata)
    );

    assign bus.mem_allow_in = allow_in;
    assign bus.to_wb_valid  = mem_valid_q && ready_go;
    assign bus.pc_out       = pc_q;
    assign bus.rf_we_out    = mem_valid_q ? rf_we_q : 4'b0000;
    assign bus.rf_waddr_out = waddr_q;
    assign bus.rf_wdata_out = is_load_q ? ld_wdata : result_q;
    assign bus.fwd_we       = mem_valid_q && (|rf_we_q);
    assign bus.fwd_block    = mem_valid_q && (state_q == MEM_WAIT) && !bus.data_sram_data_ok;
endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
`default_nettype none

module tb_mem_stage;
    import la32r_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mem_stage_if #(.DW(32), .AW(5)) bus ();

    mem_stage #(.DW(32), .AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic ld, input logic [2:0] op,
                            input logic [31:0] pc, input logic [31:0] res,
                            input logic [3:0] we, input logic [4:0] wa);
        bus.ex_to_mem_valid = v;
        bus.ex_is_load      = ld;
        bus.ex_ld_op        = op;
        bus.ex_pc           = pc;
        bus.ex_result       = res;
        bus.ex_rf_we        = we;
        bus.ex_rf_waddr     = wa;
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus.to_wb_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.to_wb_valid); end
        total++; if (bus.rf_we_out !== 4'h0) begin bad++; $display("FAIL rst_we got=%h exp=0", bus.rf_we_out); end
        total++; if (bus.mem_allow_in !== 1'b1) begin bad++; $display("FAIL rst_allow got=%b exp=1", bus.mem_allow_in); end
        total++; if ({bus.fwd_we, bus.fwd_block} !== 2'b00) begin bad++; $display("FAIL rst_fwd got=%b exp=00", {bus.fwd_we, bus.fwd_block}); end
        total++; if ({bus.pc_out, bus.rf_wdata_out} !== 64'h0) begin bad++; $display("FAIL rst_payload got=%h exp=0", {bus.pc_out, bus.rf_wdata_out}); end
        total++; if (dut.state_q !== MEM_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=0", dut.state_q); end
    endtask

    task automatic test_alu();
        bus.wb_allow_in = 1'b1;
        drive_ex(1'b1, 1'b0, LD_W, 32'h1C00_0010, 32'h1234_5678, 4'hF, 5'd5);
        cyc();
        drive_ex(1'b0, 1'b0, LD_W, 32'h0, 32'hDEAD_BEEF, 4'h0, 5'd0);
        #1;
        total++; if (bus.to_wb_valid !== 1'b1) begin bad++; $display("FAIL alu_valid got=%b exp=1", bus.to_wb_valid); end
        total++; if (bus.rf_wdata_out !== 32'h1234_5678) begin bad++; $display("FAIL alu_wdata got=%h exp=12345678", bus.rf_wdata_out); end
        total++; if ({bus.fwd_we, bus.fwd_block} !== 2'b10) begin bad++; $display("FAIL alu_fwd got=%b exp=10", {bus.fwd_we, bus.fwd_block}); end
        total++; if ({bus.pc_out, bus.rf_waddr_out, bus.rf_we_out} !== {32'h1C00_0010, 5'd5, 4'hF}) begin bad++; $display("FAIL alu_payload got=%h/%0d/%h", bus.pc_out, bus.rf_waddr_out, bus.rf_we_out); end
        cyc();
        total++; if ({bus.to_wb_valid, bus.rf_we_out, bus.fwd_we} !== 6'b0) begin bad++; $display("FAIL alu_bubble got=%b exp=0", {bus.to_wb_valid, bus.rf_we_out, bus.fwd_we}); end
    endtask

    task automatic test_load_byte();
        logic [2:0]  ops [2];
        logic [31:0] exps[2];
        ops[0] = LD_B;  exps[0] = 32'hFFFF_FF80;
        ops[1] = LD_BU; exps[1] = 32'h0000_0080;
        for (int i = 0; i < 2; i++) begin
            bus.wb_allow_in = 1'b1;
            drive_ex(1'b1, 1'b1, ops[i], 32'h1C00_0020, 32'h1000_0003, 4'hF, 5'd7);
            cyc();
            drive_ex(1'b0, 1'b0, LD_W, 32'h0, 32'h0, 4'h0, 5'd0);
            for (int k = 0; k < 2; k++) begin
                #1;
                total++; if ({bus.fwd_block, bus.to_wb_valid} !== 2'b10) begin bad++; $display("FAIL ldb_wait%0d got=%b exp=10", k, {bus.fwd_block, bus.to_wb_valid}); end
                cyc();
            end
            bus.data_sram_data_ok = 1'b1;
            bus.data_sram_rdata   = 32'h80FF_0000;
            #1;
            total++; if (bus.to_wb_valid !== 1'b1) begin bad++; $display("FAIL ldb_valid got=%b exp=1", bus.to_wb_valid); end
            total++; if (bus.rf_wdata_out !== exps[i]) begin bad++; $display("FAIL ldb_wdata%0d got=%h exp=%h", i, bus.rf_wdata_out, exps[i]); end
            total++; if (bus.fwd_block !== 1'b0) begin bad++; $display("FAIL ldb_blk got=%b exp=0", bus.fwd_block); end
            cyc();
            bus.data_sram_data_ok = 1'b0;
            #1;
            total++; if ({bus.to_wb_valid, dut.state_q} !== {1'b0, MEM_IDLE}) begin bad++; $display("FAIL ldb_done got=%b/%0d", bus.to_wb_valid, dut.state_q); end
        end
    endtask

    task automatic test_hold();
        bus.wb_allow_in = 1'b1;
        drive_ex(1'b1, 1'b1, LD_HU, 32'h1C00_0030, 32'h2000_0002, 4'hF, 5'd8);
        cyc();
        drive_ex(1'b0, 1'b0, LD_W, 32'h0, 32'h0, 4'h0, 5'd0);
        bus.wb_allow_in       = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'hBEEF_1234;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if ({bus.to_wb_valid, bus.mem_allow_in} !== 2'b10) begin bad++; $display("FAIL hold_hs%0d got=%b exp=10", k, {bus.to_wb_valid, bus.mem_allow_in}); end
            total++; if (bus.rf_wdata_out !== 32'h0000_BEEF) begin bad++; $display("FAIL hold_wdata%0d got=%h exp=0000beef", k, bus.rf_wdata_out); end
            cyc();
            bus.data_sram_data_ok = 1'b0;
            bus.data_sram_rdata   = 32'h5555_AAAA;
            #1;
            total++; if (dut.state_q !== MEM_HOLD) begin bad++; $display("FAIL hold_state%0d got=%0d exp=2", k, dut.state_q); end
        end
        bus.wb_allow_in = 1'b1;
        #1;
        total++; if (bus.mem_allow_in !== 1'b1) begin bad++; $display("FAIL hold_rel got=%b exp=1", bus.mem_allow_in); end
        cyc();
        total++; if ({bus.to_wb_valid, dut.state_q} !== {1'b0, MEM_IDLE}) begin bad++; $display("FAIL hold_done got=%b/%0d", bus.to_wb_valid, dut.state_q); end
    endtask

    task automatic test_back_to_back();
        int xfers;
        xfers = 0;
        bus.wb_allow_in = 1'b1;
        drive_ex(1'b1, 1'b1, LD_W, 32'h1C00_0040, 32'h3000_0000, 4'hF, 5'd3);
        cyc();
        drive_ex(1'b0, 1'b0, LD_W, 32'h0, 32'h0, 4'h0, 5'd0);
        cyc();
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'hCAFE_F00D;
        drive_ex(1'b1, 1'b1, LD_H, 32'h1C00_0044, 32'h3000_0006, 4'hF, 5'd9);
        #1;
        total++; if ({bus.to_wb_valid, bus.mem_allow_in} !== 2'b11) begin bad++; $display("FAIL b2b_hs1 got=%b exp=11", {bus.to_wb_valid, bus.mem_allow_in}); end
        total++; if ({bus.rf_wdata_out, bus.rf_waddr_out} !== {32'hCAFE_F00D, 5'd3}) begin bad++; $display("FAIL b2b_first got=%h/%0d exp=cafef00d/3", bus.rf_wdata_out, bus.rf_waddr_out); end
        cyc();
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'h0;
        drive_ex(1'b0, 1'b0, LD_W, 32'h0, 32'h0, 4'h0, 5'd0);
        #1;
        total++; if (dut.state_q !== MEM_WAIT) begin bad++; $display("FAIL b2b_state got=%0d exp=1", dut.state_q); end
        total++; if ({bus.to_wb_valid, bus.fwd_block, bus.rf_waddr_out} !== {2'b01, 5'd9}) begin bad++; $display("FAIL b2b_wait got=%b/%0d", {bus.to_wb_valid, bus.fwd_block}, bus.rf_waddr_out); end
        cyc();
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h8001_7FFF;
        #1;
        total++; if ({bus.to_wb_valid, bus.rf_wdata_out} !== {1'b1, 32'hFFFF_8001}) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/ffff8001", bus.to_wb_valid, bus.rf_wdata_out); end
        cyc();
        bus.data_sram_data_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (bus.to_wb_valid) xfers++;
            cyc();
        end
        total++; if (xfers !== 0) begin bad++; $display("FAIL b2b_dup got=%0d exp=0", xfers); end
    endtask

    task automatic test_spurious();
        bus.wb_allow_in       = 1'b1;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h1111_2222;
        #1;
        total++; if (bus.to_wb_valid !== 1'b0) begin bad++; $display("FAIL spur_valid got=%b exp=0", bus.to_wb_valid); end
        cyc();
        bus.data_sram_data_ok = 1'b0;
        #1;
        total++; if ({bus.to_wb_valid, bus.mem_allow_in, dut.state_q} !== {2'b01, MEM_IDLE}) begin bad++; $display("FAIL spur_state got=%b/%0d", {bus.to_wb_valid, bus.mem_allow_in}, dut.state_q); end
    endtask

    task automatic test_reset_mid();
        bus.wb_allow_in = 1'b1;
        drive_ex(1'b1, 1'b1, LD_W, 32'h1C00_0050, 32'h4000_0000, 4'hF, 5'd4);
        cyc();
        drive_ex(1'b0, 1'b0, LD_W, 32'h0, 32'h0, 4'h0, 5'd0);
        #1;
        total++; if (dut.state_q !== MEM_WAIT) begin bad++; $display("FAIL rmid_pre got=%0d exp=1", dut.state_q); end
        reset = 1'b0;
        cyc();
        total++; if ({bus.to_wb_valid, bus.rf_we_out, bus.mem_allow_in} !== 6'b000001) begin bad++; $display("FAIL rmid_out got=%b exp=000001", {bus.to_wb_valid, bus.rf_we_out, bus.mem_allow_in}); end
        total++; if (dut.state_q !== MEM_IDLE) begin bad++; $display("FAIL rmid_state got=%0d exp=0", dut.state_q); end
        reset = 1'b1;
        cyc();
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h7777_7777;
        #1;
        total++; if (bus.to_wb_valid !== 1'b0) begin bad++; $display("FAIL rmid_late got=%b exp=0", bus.to_wb_valid); end
        cyc();
        bus.data_sram_data_ok = 1'b0;
        #1;
        total++; if (dut.state_q !== MEM_IDLE) begin bad++; $display("FAIL rmid_after got=%0d exp=0", dut.state_q); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        drive_ex(1'b0, 1'b0, LD_W, 32'h0, 32'h0, 4'h0, 5'd0);
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'h0;
        bus.wb_allow_in       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        test_reset();
        cyc();
        test_alu();
        test_load_byte();
        test_hold();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
